apb_cmd_sequencer: RTL and testbench

- Command front-end that sits directly upstream of the APB top-level (master plus two address-decoded slaves).
- Accepts read/write commands on a valid/ready stream, buffers them in a small FIFO, and drives the top-level's start/write/addr/wdata one transaction at a time.
- Waits for pready, then captures prdata/pslverr into a response stream with its own valid/ready handshake.
- Adds a wait-state timeout so a hung slave cannot stall the command stream.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_cmd_fifo.sv | 58 +++++
 rtl/apb_cmd_sequencer.sv | 128 ++++++++++++
 tb/tb_apb_cmd_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB command front-end.
// Both the command FIFO and the sequencer import this package.
package apb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Small synchronous FIFO holding queued APB commands.
// DEPTH must be a power of two so the pointers wrap on their own.
module apb_cmd_fifo
    import apb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  apb_cmd_t               push_data,
    input  logic                   pop,
    output apb_cmd_t               pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    apb_cmd_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the pointers and level alone
    // decide which entries are valid, so clearing the data would be wasted logic.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/apb_cmd_sequencer.sv
// Command front-end for the APB top: queues commands, issues them one at a time,
// and returns one response per command, aborting hung transfers after TIMEOUT cycles.
module apb_cmd_sequencer
    import apb_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [DATA_W-1:0]      cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic                   rsp_timeout,
    output logic                   start,
    output logic                   write,
    output logic [ADDR_W-1:0]      addr,
    output logic [DATA_W-1:0]      wdata,
    input  logic [DATA_W-1:0]      prdata,
    input  logic                   pready,
    input  logic                   pslverr,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_seen;
    logic             fifo_pop;
    apb_cmd_t         cmd_in;
    apb_cmd_t         head;

    assign cmd_in    = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    assign cmd_ready = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;

    // From IDLE the non-empty flag is seen one cycle late, so a fresh command
    // always sits in the FIFO for a cycle; back-to-back issue from RESP is immediate.
    assign fifo_pop = !fifo_empty &&
                      (((state == IDLE) && fifo_seen) || ((state == RESP) && rsp_ready));

    apb_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (cmd_valid),
        .push_data (cmd_in),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            fifo_seen   <= 1'b0;
            start       <= 1'b0;
            write       <= 1'b0;
            addr        <= '0;
            wdata       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            fifo_seen <= !fifo_empty;
            start     <= 1'b0;

            case (state)
                IDLE: begin
                    if (fifo_pop) state <= ISSUE;
                end
                ISSUE: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (pready) begin
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= write ? '0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        state       <= RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= fifo_pop ? ISSUE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Both pop points load the head entry and raise the one-cycle start.
            if (fifo_pop) begin
                start <= 1'b1;
                write <= head.write;
                addr  <= head.addr;
                wdata <= head.wdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Directed bench for apb_cmd_sequencer: a behavioural slave answers each start,
// and scoreboards hold the expected issued commands and responses in order.
module tb_apb_cmd_sequencer;
    import apb_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;
    logic       start;
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] prdata = '0;
    logic       pready = 1'b0;
    logic       pslverr = 1'b0;
    logic       busy;
    logic [2:0] level;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        logic       tmo;
    } rsp_t;

    typedef struct {
        int         delay;
        logic [7:0] prdata;
        logic       slverr;
        logic       hang;
        logic       glitch;
    } slv_t;

    rsp_t     exp_rsp[$];
    apb_cmd_t exp_cmd[$];
    slv_t     slv_q[$];
    int       start_cyc[$];
    int       total = 0;
    int       bad = 0;
    int       cyc = 0;
    int       starts = 0;

    apb_cmd_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .start       (start),
        .write       (write),
        .addr        (addr),
        .wdata       (wdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr),
        .busy        (busy),
        .level       (level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic rsp_t model(input logic w, input logic [7:0] pd, input logic se,
                                   input logic hang);
        rsp_t r;
        if (hang) begin
            r.rdata = 8'h00; r.err = 1'b1; r.tmo = 1'b1;
        end else begin
            r.rdata = w ? 8'h00 : pd; r.err = se; r.tmo = 1'b0;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one command and hold it until accepted; expectations are queued at acceptance.
    task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input int dly, input logic [7:0] pd, input logic se,
                        input logic hang, input logic glitch);
        int       n = 0;
        apb_cmd_t c;
        slv_t     s;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", cmd_ready, 1'b1);
        end else begin
            c = '{write: w, addr: a, wdata: d};
            s = '{delay: dly, prdata: pd, slverr: se, hang: hang, glitch: glitch};
            exp_cmd.push_back(c);
            slv_q.push_back(s);
            exp_rsp.push_back(model(w, pd, se, hang));
            @(posedge clk);
        end
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!start && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_start_seen"}, start, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || rsp_valid || exp_rsp.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_drained"}, exp_rsp.size(), 0);
    endtask

    // Behavioural slave: checks the issued command, then raises pready after the
    // configured number of WAIT cycles (or never, for a hung transfer).
    initial begin
        apb_cmd_t c;
        slv_t     s;
        forever begin
            @(negedge clk);
            if (resetn && start) begin
                starts++;
                start_cyc.push_back(cyc);
                if (exp_cmd.size() == 0 || slv_q.size() == 0) begin
                    check("start_unexpected", start, 1'b0);
                end else begin
                    c = exp_cmd.pop_front();
                    s = slv_q.pop_front();
                    check("cmd_write", write, c.write);
                    check("cmd_addr", addr, c.addr);
                    check("cmd_wdata", wdata, c.wdata);
                    if (s.glitch) pready = 1'b1;
                    @(negedge clk);
                    pready = 1'b0;
                    check("start_one_cycle", start, 1'b0);
                    if (!s.hang) begin
                        repeat (s.delay) @(negedge clk);
                        check("addr_held", addr, c.addr);
                        check("wdata_held", wdata, c.wdata);
                        pready = 1'b1; prdata = s.prdata; pslverr = s.slverr;
                        @(negedge clk);
                        pready = 1'b0; prdata = '0; pslverr = 1'b0;
                    end
                end
            end
        end
    end

    // Response scoreboard: compare on every handshake, in order.
    always @(negedge clk) begin
        if (resetn && rsp_valid && rsp_ready) begin
            if (exp_rsp.size() == 0) begin
                check("rsp_unexpected", rsp_valid, 1'b0);
            end else begin
                rsp_t e;
                e = exp_rsp.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", rsp_err, e.err);
                check("rsp_timeout", rsp_timeout, e.tmo);
            end
        end
    end

    initial begin
        int k;
        int base;
        logic saw_valid;
        logic saw_start;

        // Reset state
        #1;
        check("rst_outputs",
              {start, write, addr, wdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, '0);
        check("rst_level", level, 3'd0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // Single write: start appears two edges after acceptance
        rsp_ready = 1'b1;
        send(1'b1, 8'h10, 8'hA5, 0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("wr_level_after_push", level, 3'd1);
        check("wr_no_start_n", start, 1'b0);
        tick();
        check("wr_no_start_n1", start, 1'b0);
        tick();
        check("wr_start_n2", start, 1'b1);
        check("wr_addr", addr, 8'h10);
        check("wr_wdata", wdata, 8'hA5);
        wait_idle("wr");

        // Single read with error after 3 WAIT cycles, pready glitch during ISSUE
        rsp_ready = 1'b0;
        send(1'b0, 8'h90, 8'h00, 3, 8'h3C, 1'b1, 1'b0, 1'b1);
        wait_start("rd");
        k = 0;
        while (!rsp_valid && k < 40) begin
            tick();
            k++;
        end
        check("rd_latency", k, 5);
        for (int i = 0; i < 4; i++) begin
            check("rd_valid_held", rsp_valid, 1'b1);
            check("rd_rdata_held", rsp_rdata, 8'h3C);
            check("rd_err_held", rsp_err, 1'b1);
            tick();
        end
        rsp_ready = 1'b1;
        wait_idle("rd");

        // FIFO full while the first command hangs in WAIT
        base = starts;
        send(1'b1, 8'h20, 8'h11, 0, 8'h00, 1'b0, 1'b1, 1'b0);
        wait_start("full");
        send(1'b0, 8'h21, 8'h00, 1, 8'h55, 1'b0, 1'b0, 1'b0);
        send(1'b1, 8'h22, 8'h66, 2, 8'h00, 1'b0, 1'b0, 1'b0);
        send(1'b0, 8'hA0, 8'h00, 0, 8'h77, 1'b1, 1'b0, 1'b0);
        send(1'b0, 8'h23, 8'h00, TIMEOUT - 1, 8'h88, 1'b0, 1'b0, 1'b0);
        check("full_level", level, 3'd4);
        check("full_cmd_ready", cmd_ready, 1'b0);
        check("full_busy", busy, 1'b1);
        send(1'b1, 8'hFF, 8'hC3, 4, 8'h00, 1'b0, 1'b0, 1'b0);
        check("full_accept_after_pop", starts - base, 2);
        wait_idle("full");

        // Back-to-back reads: start every 3 cycles, simultaneous push/pop
        base = start_cyc.size();
        send(1'b0, 8'h30, 8'h00, 0, 8'h01, 1'b0, 1'b0, 1'b0);
        send(1'b0, 8'h31, 8'h00, 0, 8'h02, 1'b0, 1'b0, 1'b0);
        send(1'b0, 8'h32, 8'h00, 0, 8'h03, 1'b0, 1'b0, 1'b0);
        check("b2b_push_pop_level", level, 3'd2);
        wait_idle("b2b");
        check("b2b_start_count", start_cyc.size() - base, 3);
        if (start_cyc.size() - base == 3) begin
            check("b2b_gap1", start_cyc[base+1] - start_cyc[base], 3);
            check("b2b_gap2", start_cyc[base+2] - start_cyc[base+1], 3);
        end

        // Timeout, then a queued read issues normally
        send(1'b0, 8'h40, 8'h00, 0, 8'h00, 1'b0, 1'b1, 1'b0);
        send(1'b0, 8'h41, 8'h00, 2, 8'h5A, 1'b0, 1'b0, 1'b0);
        wait_start("tmo");
        k = 0;
        while (!rsp_valid && k < 60) begin
            tick();
            k++;
        end
        check("tmo_latency", k, TIMEOUT + 1);
        check("tmo_flag", rsp_timeout, 1'b1);
        check("tmo_rdata", rsp_rdata, 8'h00);
        wait_idle("tmo");

        // Reset in the middle of WAIT with two commands queued
        send(1'b1, 8'h50, 8'h01, 0, 8'h00, 1'b0, 1'b1, 1'b0);
        wait_start("mid");
        send(1'b0, 8'h51, 8'h00, 0, 8'h10, 1'b0, 1'b0, 1'b0);
        send(1'b0, 8'h52, 8'h00, 0, 8'h20, 1'b0, 1'b0, 1'b0);
        check("mid_level", level, 3'd2);
        #2;
        resetn = 1'b0;
        exp_rsp.delete();
        exp_cmd.delete();
        slv_q.delete();
        #1;
        check("mid_rst_outputs",
              {start, write, addr, wdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, '0);
        check("mid_rst_level", level, 3'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_cmd_ready", cmd_ready, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        saw_valid = 1'b0;
        saw_start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            saw_valid |= rsp_valid;
            saw_start |= start;
        end
        check("post_rst_no_rsp", saw_valid, 1'b0);
        check("post_rst_no_start", saw_start, 1'b0);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_level", level, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
